// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
//   pc_seq_state_t : fetch FSM states (RUN / DRAIN / HALTED)
//   pc_seq_entry_t : queue entry {instr, pc} at the default widths
//   DEF_*          : default parameter values used by pc_sequencer
package pc_seq_pkg;

  localparam int DEF_PC_W     = 10;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_STEP     = 4;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pc_seq_state_t;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc;
  } pc_seq_entry_t;

  // True when a queue holding 'count' entries is empty once this cycle's pop retires.
  function automatic logic will_be_empty(input logic [1:0] count, input logic pop);
    return (count == 2'd0) || ((count == 2'd1) && pop);
  endfunction

endpackage

// File: rtl/pc_sequencer_fifo.sv
// Two-entry FIFO with a registered head toward decode.
//   clk, reset      : clock, synchronous active-high reset
//   push_i, din_i   : write an entry
//   pop_i           : retire the head (ignored when empty)
//   flush_i         : drop all entries; wins over push
//   head_o, valid_o : registered head entry and its valid flag
//   count_o         : number of entries held (0..2)
module inst_fifo2 #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok_s;

  // Next contents of the two slots; slot0 is always the head.
  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    count_d  = count_q;
    pop_ok_s = pop_i && (count_q != 2'd0);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_ok_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = din_i;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            slot1_d = din_i;
            count_d = 2'd2;
          end else begin
            count_d = count_q;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind the survivor.
          if (count_q == 2'd1) begin
            slot0_d = din_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = din_i;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Slot and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot0_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, drives instruction memory,
// queues fetched words toward decode and handles branch redirect and halt/drain.
//   clk, reset                          : clock, synchronous active-high reset
//   imem_req, imem_addr                 : fetch request and address (= fetch PC)
//   imem_ready, imem_data               : same-cycle response for imem_addr
//   inst_valid, inst, inst_pc, inst_ready : queue head handshake toward decode
//   branch_enable, target               : redirect fetch (low two bits cleared)
//   halt, halted                        : sticky stop request, halted-and-empty flag
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int STEP     = DEF_STEP,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [PC_W-1:0]    inst_pc,
  input  logic               inst_ready,
  input  logic               branch_enable,
  input  logic [PC_W-1:0]    target,
  input  logic               halt,
  output logic               halted
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  pc_seq_state_t          state_q, state_d;
  logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [1:0]             count_s;
  logic                   push_s, pop_s, flush_s, redirect_s;
  logic [INSTR_W+PC_W-1:0] head_s;

  inst_fifo2 #(.W(INSTR_W + PC_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .din_i   ({imem_data, imem_addr}),
    .head_o  (head_s),
    .valid_o (inst_valid),
    .count_o (count_s)
  );

  assign pop_s   = inst_valid && inst_ready;
  assign inst    = head_s[INSTR_W+PC_W-1:PC_W];
  assign inst_pc = head_s[PC_W-1:0];

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= PC_W'(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next state: halt leaves RUN, draining ends once the queue empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = will_be_empty(count_s, pop_s) ? HALTED : DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (will_be_empty(count_s, pop_s)) begin
          state_d = HALTED;
        end else begin
          state_d = DRAIN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Fetch request, queue control and next fetch PC; halt beats redirect beats sequential fetch.
  always_comb begin
    imem_req   = (!reset) && (state_q == RUN) && (count_s != 2'd2);
    redirect_s = (state_q == RUN) && !halt && branch_enable;
    flush_s    = redirect_s;
    // A response arriving alongside halt or redirect is dropped.
    push_s     = imem_req && imem_ready && !halt && !branch_enable;
    if (redirect_s) begin
      fetch_pc_d = target & ALIGN_MASK;
    end else if (push_s) begin
      fetch_pc_d = fetch_pc_q + PC_W'(STEP);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;
  localparam int PC_MOD  = 1024;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready = 1'b0;
  logic [INSTR_W-1:0] imem_data = '0;
  logic               inst_valid;
  logic [INSTR_W-1:0] inst;
  logic [PC_W-1:0]    inst_pc;
  logic               inst_ready = 1'b0;
  logic               branch_enable = 1'b0;
  logic [PC_W-1:0]    target = '0;
  logic               halt = 1'b0;
  logic               halted;

  pc_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .STEP(4), .RESET_PC(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .branch_enable (branch_enable),
    .target        (target),
    .halt          (halt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          pc;
  } ent_t;

  // Behavioural model: a queue of delivered words, the fetch PC and a mode flag.
  ent_t q[$];
  int   m_pc;
  int   m_mode;   // 0 = run, 1 = drain, 2 = halted
  bit   known = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_word(input int a);
    return 32'hA500_0000 ^ (a * 32'h0000_9E37) ^ (a << 20);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step(input bit rst, input bit rdy, input bit irdy, input bit br,
                      input int tgt, input bit hlt);
    bit   exp_req, pop;
    ent_t e;
    reset = rst; imem_ready = rdy; inst_ready = irdy;
    branch_enable = br; halt = hlt; target = tgt[PC_W-1:0];
    imem_data = mem_word(int'(imem_addr));
    #1;
    exp_req = !rst && (m_mode == 0) && (q.size() < 2);
    if (known) begin
      check_eq("imem_req", 64'(imem_req), 64'(exp_req));
      check_eq("imem_addr", 64'(imem_addr), 64'(m_pc));
      check_eq("inst_valid", 64'(inst_valid), 64'(q.size() > 0));
      check_eq("halted", 64'(halted), 64'(m_mode == 2));
      if (q.size() > 0) begin
        check_eq("inst", 64'(inst), 64'(q[0].instr));
        check_eq("inst_pc", 64'(inst_pc), 64'(q[0].pc));
      end
    end
    if (rst) begin
      q.delete(); m_pc = 0; m_mode = 0; known = 1'b1;
    end else begin
      pop = (q.size() > 0) && irdy;
      if (m_mode == 0) begin
        if (hlt) begin
          if (pop) void'(q.pop_front());
          m_mode = (q.size() == 0) ? 2 : 1;
        end else if (br) begin
          q.delete();
          m_pc = (tgt % PC_MOD) / 4 * 4;
        end else begin
          if (pop) void'(q.pop_front());
          if (exp_req && rdy) begin
            e.instr = mem_word(m_pc); e.pc = m_pc;
            q.push_back(e);
            m_pc = (m_pc + 4) % PC_MOD;
          end
        end
      end else if (m_mode == 1) begin
        if (pop) void'(q.pop_front());
        if (q.size() == 0) m_mode = 2;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset, then back-to-back fetch from 0.
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);
    // Decode stalls: queue fills and requests stop, then drains in order.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
    // Redirect to a misaligned target with a full queue.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 'h103, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
    // Redirect with a live response in the same cycle.
    step(0, 1, 1, 1, 'h2F1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    // Address wrap: 1016, 1020, 0, 4.
    step(0, 1, 1, 1, 1016, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);
    // Halt with two queued entries, later branch ignored.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 'h80, 0);
    step(0, 1, 1, 0, 0, 0);
    // Halt and branch together, then reset while draining.
    step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 'h200, 1);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8,
           int'($urandom_range(0, 1023)), $urandom_range(0, 199) < 2);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch controller that owns the program counter and drives instruction memory. It issues sequential fetches at `pc + STEP` and applies branch redirects from execute. It buffers fetched words in a 2-entry queue toward decode and handles halt with drain. It sits between instruction memory and the decode stage and replaces direct PC increment logic in the core.

## Interface
Parameters:
- `PC_W`, 10: program counter / instruction address width
- `INSTR_W`, 32: instruction word width
- `STEP`, 4: sequential PC increment (bytes)
- `RESET_PC`, 0: PC value after reset

Ports:
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `imem_req`  out  1  fetch request valid for `imem_addr`
- `imem_addr`  out  PC_W  fetch address (= fetch PC)
- `imem_ready`  in  1  `imem_data` valid for the address presented in this same cycle
- `imem_data`  in  INSTR_W  instruction word
- `inst_valid`  out  1  queue head valid toward decode
- `inst`  out  INSTR_W  queue head instruction
- `inst_pc`  out  PC_W  address of queue head instruction
- `inst_ready`  in  1  decode accepts head this cycle
- `branch_enable`  in  1  redirect fetch to `target`
- `target`  in  PC_W  redirect address
- `halt`  in  1  stop fetching (sticky until reset)
- `halted`  out  1  halted and queue empty

## Operation
- States: RUN, DRAIN, HALTED.
  - RUN: `imem_req` = (queue count < 2). On `imem_req & imem_ready`: push {`imem_data`, `imem_addr`}. Set fetch_pc <= fetch_pc + STEP.
  - DRAIN: `imem_req` = 0. The queue keeps delivering to decode. Go to HALTED when the queue is empty after this cycle's pop.
  - HALTED: `imem_req` = 0, `halted` = 1. Exit only via `reset`.
- Transition RUN -> DRAIN on `halt`. If the queue is already empty, or will be empty after this cycle's pop, go directly to HALTED.
- Priority: reset > halt > branch_enable > sequential fetch.
  - `halt` and `branch_enable` in the same cycle: halt wins and the redirect is dropped.
- Redirect (`branch_enable` in RUN):
  - fetch_pc <= {target[PC_W-1:2], 2'b00}; misaligned low bits are cleared.
  - The queue is flushed (count <= 0).
  - Any `imem_ready` response in the same cycle is discarded: no push, no increment.
  - A pop in the same cycle is legal and has no further effect.
- `branch_enable` in DRAIN or HALTED is ignored.
- Dequeue occurs when `inst_valid & inst_ready`. Push and pop in the same cycle with count = 2 is not possible, because no request is issued at count 2.
- PC arithmetic is modulo 2^PC_W. Example: 1020 + 4 -> 0 with no flag.
- `imem_addr` may change in any cycle. Memory must not rely on address hold when `imem_ready` = 0 (wait-state SRAM semantics; the response is for the current address only).

## Timing
- Reset values: fetch_pc = RESET_PC, state = RUN, queue count = 0, `inst_valid` = 0, `halted` = 0.
  - `imem_req` = 0 while `reset` is high.
  - `imem_req` = 1 with `imem_addr` = RESET_PC in the first cycle after reset deasserts.
- Fetch latency: an accepted fetch at cycle N makes `inst_valid` = 1 at N+1 (the queue output is registered).
- Sustained throughput: 1 instruction/cycle when `imem_ready` and `inst_ready` are held high.
- Redirect at cycle N:
  - `inst_valid` = 0 at N+1.
  - `imem_addr` = target with `imem_req` = 1 at N+1.
  - The first target instruction is visible at N+2 at the earliest.
- `halt` at cycle N: `imem_req` = 0 from N+1. `halted` rises one cycle after the last queue entry pops.
- Reset mid-operation (any state, queue contents): all state returns to reset values next cycle and in-flight data is dropped.
- No combinational path from `inst_ready` to `imem_req`.

## Structure
- Package `pc_seq_pkg`:
  - `pc_seq_state_t` enum {RUN, DRAIN, HALTED}
  - default constants STEP and RESET_PC
  - typedef for a queue entry {instr, pc}
- Sub-module `inst_fifo2`: 2-entry FIFO with push/pop/flush, count output, registered head. Flush has priority over push.
- The top level holds the FSM, fetch_pc register and redirect/halt priority logic.

## Test plan
- Reset release, `imem_ready` = 1, `inst_ready` = 1 -> addresses 0,4,8,12… issued back-to-back. `inst_pc` follows one cycle later, one instruction per cycle.
- `inst_ready` = 0 for 5 cycles -> exactly 2 entries queued (pc 0,4) and `imem_req` drops. Raise `inst_ready` -> 0,4,8 delivered in order with no loss or duplication.
- Redirect with `target` = 0x103 while the queue is full and `imem_ready` = 1 -> next `imem_addr` = 0x100, queue emptied, the same-cycle response is not delivered, and the next `inst_pc` = 0x100.
- Start at fetch_pc = 1016 -> sequence 1016, 1020, 0, 4.
- `halt` with 2 entries queued and `inst_ready` = 1 -> `imem_req` = 0 next cycle, both entries delivered, then `halted` = 1. A later `branch_enable` is ignored.
- `halt` and `branch_enable` in the same cycle -> no redirect, halt path taken. `reset` asserted in DRAIN -> RUN at RESET_PC with `inst_valid` = 0.
